puf_meas_sched: RTL and testbench
=================================

PUF_MEAS_SCHED -- requirements
Module: puf_meas_sched

Interface
REQ-001 Parameter N_BITS, default 256: response bits produced per run.
REQ-002 Parameter WIN_W, default 8: width of the measurement-window length.
REQ-003 Parameter SETTLE_CYC, default 2: idle cycles after counting stops, before the compare/shift.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; sampled only in IDLE; starts one full response run.
REQ-007 abort  in  1  level; ends a run in progress, with no done.
REQ-008 window  in  WIN_W  RO counting window in clk cycles; sampled at start.
REQ-009 lfsr_seed_dv  out  1  loads the challenge seed into the LFSR.
REQ-010 lfsr_en  out  1  advances the challenge LFSR by one step.
REQ-011 ro_en  out  1  enables both ring-oscillator banks.
REQ-012 cnt_en  out  1  enables both RO edge counters.
REQ-013 cnt_reset  out  1  clears both RO edge counters.
REQ-014 sr_en  out  1  shifts the comparator winner into the response register.
REQ-015 bit_idx  out  $clog2(N_BITS)  index of the bit under measurement.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when all N_BITS have been shifted in.

Function
REQ-018 FSM states: IDLE, SEED, CLEAR, MEASURE, SETTLE, SHIFT, FIN; all outputs are registered Moore outputs of the state.
REQ-019 IDLE: if start=1, latch window (0 is coerced to 1), clear bit_idx, go to SEED; else stay.
REQ-020 SEED: lfsr_seed_dv=1 for exactly one cycle, then CLEAR.
REQ-021 CLEAR: cnt_reset=1 for exactly one cycle, then MEASURE.
REQ-022 MEASURE: ro_en=1 and cnt_en=1 for exactly the latched window cycles (internal counter 0..window-1), then SETTLE.
REQ-023 SETTLE: ro_en=0 and cnt_en=0 for exactly SETTLE_CYC cycles, then SHIFT.
REQ-024 SHIFT: sr_en=1 and lfsr_en=1 together for exactly one cycle.
REQ-025 SHIFT exit: if bit_idx=N_BITS-1, go to FIN; else increment bit_idx and go to CLEAR.
REQ-026 FIN: done=1 for one cycle, then IDLE; bit_idx holds N_BITS-1 until the next start.
REQ-027 Per-bit latency is 1+window+SETTLE_CYC+1 cycles; run latency is 1+N_BITS*(window+SETTLE_CYC+2)+1 cycles from start to the done pulse.
REQ-028 start while busy=1 is ignored; window changes while busy=1 are ignored.
REQ-029 start held high through FIN begins a new run on the cycle after FIN.
REQ-030 abort=1 in any non-IDLE state: next state IDLE, all strobes 0 that cycle, done not asserted; abort has priority over every transition.
REQ-031 abort=1 in IDLE with start=1: remain in IDLE.
REQ-032 The window counter and bit_idx do not wrap inside a run; bit_idx never exceeds N_BITS-1.

Reset
REQ-033 reset=1 forces IDLE and bit_idx=0; all outputs are 0 on the next cycle; reset has priority over abort and start.
REQ-034 reset mid-run discards progress; the following run reseeds from SEED.

Structure
REQ-035 The shared package holds the FSM state enum and the default N_BITS, WIN_W and SETTLE_CYC constants.
REQ-036 One sub-module, puf_win_timer, is a loadable down-counter with a zero flag, used for both MEASURE and SETTLE.

Verification
REQ-037 N_BITS=4, window=3, start pulse: sequence is seed(1), clear(1), meas(3), settle(2), shift(1) x4; done at cycle 30; 4 sr_en and 4 lfsr_en pulses.
REQ-038 window=0: each MEASURE lasts exactly 1 cycle.
REQ-039 abort asserted on the 2nd MEASURE cycle of bit 2: IDLE next cycle, busy=0, no done, no further strobes.
REQ-040 reset during SETTLE: all outputs 0 next cycle; a new start gives a full 4-bit run with a fresh lfsr_seed_dv.
REQ-041 start held high continuously: done pulses at a period of exactly run latency+1; start pulses during busy=1 change nothing.
REQ-042 Default parameters, window=255: done after 1+256*259+1 = 66306 cycles; bit_idx=255 at done.

Source files
------------

// File: rtl/puf_meas_sched_pkg.sv
// Shared types and default sizing for the PUF measurement scheduler.
package puf_meas_sched_pkg;

  localparam int DEF_N_BITS     = 256;
  localparam int DEF_WIN_W      = 8;
  localparam int DEF_SETTLE_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_CLEAR,
    ST_MEASURE,
    ST_SETTLE,
    ST_SHIFT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/puf_meas_sched_win_timer.sv
// Loadable down-counter with a zero flag; times both the counting window and the settle gap.
module puf_win_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Decrement saturates at zero so the count never wraps inside a phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/puf_meas_sched.sv
// Sequences one PUF response run: seed the challenge LFSR, then per bit clear/measure/settle/shift.
module puf_meas_sched
  import puf_meas_sched_pkg::*;
#(
  parameter int N_BITS     = DEF_N_BITS,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [WIN_W-1:0]          window,
  output logic                      lfsr_seed_dv,
  output logic                      lfsr_en,
  output logic                      ro_en,
  output logic                      cnt_en,
  output logic                      cnt_reset,
  output logic                      sr_en,
  output logic [$clog2(N_BITS)-1:0] bit_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int IDX_W = $clog2(N_BITS);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TW    = (WIN_W > SET_W) ? WIN_W : SET_W;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_BITS - 1);
  localparam logic [TW-1:0]    SETTLE_LOAD = TW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_t           state;
  state_t           next_state;
  logic [WIN_W-1:0] win_lat;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [TW-1:0]    tmr_val;

  // Abort overrides every transition, including a start seen in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = ST_SEED;
      ST_SEED:    next_state = ST_CLEAR;
      ST_CLEAR:   next_state = ST_MEASURE;
      ST_MEASURE: if (tmr_zero) next_state = (SETTLE_CYC > 0) ? ST_SETTLE : ST_SHIFT;
      ST_SETTLE:  if (tmr_zero) next_state = ST_SHIFT;
      ST_SHIFT:   next_state = (bit_idx == LAST_IDX) ? ST_FIN : ST_CLEAR;
      ST_FIN:     next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    if (abort) next_state = ST_IDLE;
  end

  // Timer holds "cycles left minus one": loaded on the cycle before each timed phase begins.
  always_comb begin
    tmr_load = (state == ST_CLEAR) || ((state == ST_MEASURE) && tmr_zero);
    tmr_val  = (state == ST_CLEAR) ? (TW'(win_lat) - TW'(1)) : SETTLE_LOAD;
    tmr_dec  = (state == ST_MEASURE) || (state == ST_SETTLE);
  end

  puf_win_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Outputs are decoded from the next state so each strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      win_lat      <= '0;
      bit_idx      <= '0;
      lfsr_seed_dv <= 1'b0;
      lfsr_en      <= 1'b0;
      ro_en        <= 1'b0;
      cnt_en       <= 1'b0;
      cnt_reset    <= 1'b0;
      sr_en        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == ST_IDLE) && (next_state == ST_SEED)) begin
        win_lat <= (window == '0) ? WIN_W'(1) : window;
        bit_idx <= '0;
      end
      if ((state == ST_SHIFT) && (next_state == ST_CLEAR)) begin
        bit_idx <= bit_idx + IDX_W'(1);
      end
      lfsr_seed_dv <= (next_state == ST_SEED);
      cnt_reset    <= (next_state == ST_CLEAR);
      ro_en        <= (next_state == ST_MEASURE);
      cnt_en       <= (next_state == ST_MEASURE);
      sr_en        <= (next_state == ST_SHIFT);
      lfsr_en      <= (next_state == ST_SHIFT);
      done         <= (next_state == ST_FIN);
      busy         <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_puf_meas_sched.sv
// Self-checking bench: per-cycle expected output traces are generated from the run-length rules.
module tb_puf_meas_sched;

  localparam int NB = 4;
  localparam int S  = 2;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] window;
  logic       lfsr_seed_dv, lfsr_en, ro_en, cnt_en, cnt_reset, sr_en, busy, done;
  logic [1:0] bit_idx;

  logic       d_reset, d_start, d_abort;
  logic [7:0] d_window;
  logic       d_seed, d_lfsr, d_ro, d_cnt, d_clr, d_sr, d_busy, d_done;
  logic [7:0] d_bit_idx;

  int vectors    = 0;
  int miscompares = 0;

  logic [9:0] exp_q[$];
  logic [9:0] obs;

  assign obs = {lfsr_seed_dv, lfsr_en, cnt_reset, ro_en, cnt_en, sr_en, done, busy, bit_idx};

  always #5 clk = ~clk;

  puf_meas_sched #(.N_BITS(NB), .WIN_W(8), .SETTLE_CYC(S)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .window(window),
    .lfsr_seed_dv(lfsr_seed_dv), .lfsr_en(lfsr_en), .ro_en(ro_en), .cnt_en(cnt_en),
    .cnt_reset(cnt_reset), .sr_en(sr_en), .bit_idx(bit_idx), .busy(busy), .done(done)
  );

  puf_meas_sched dut_def (
    .clk(clk), .reset(d_reset), .start(d_start), .abort(d_abort), .window(d_window),
    .lfsr_seed_dv(d_seed), .lfsr_en(d_lfsr), .ro_en(d_ro), .cnt_en(d_cnt),
    .cnt_reset(d_clr), .sr_en(d_sr), .bit_idx(d_bit_idx), .busy(d_busy), .done(d_done)
  );

  // Expected output word in the same bit order as obs.
  function automatic logic [9:0] ev(input bit seed, input bit clr, input bit meas,
                                    input bit shift, input bit fin, input bit bsy, input int idx);
    logic [1:0] i2;
    i2 = idx[1:0];
    return {seed, shift, clr, meas, meas, shift, fin, bsy, i2};
  endfunction

  task automatic push_run(input int w);
    int weff;
    weff = (w == 0) ? 1 : w;
    exp_q.push_back(ev(1, 0, 0, 0, 0, 1, 0));
    for (int b = 0; b < NB; b++) begin
      exp_q.push_back(ev(0, 1, 0, 0, 0, 1, b));
      repeat (weff) exp_q.push_back(ev(0, 0, 1, 0, 0, 1, b));
      repeat (S) exp_q.push_back(ev(0, 0, 0, 0, 0, 1, b));
      exp_q.push_back(ev(0, 0, 0, 1, 0, 1, b));
    end
    exp_q.push_back(ev(0, 0, 0, 0, 1, 1, NB - 1));
  endtask

  task automatic test_reset();
    reset = 1; start = 1; abort = 1; window = 8'd5;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs !== 10'b0) begin
      miscompares++; $display("[TB] FAIL reset_outputs got %b want %b", obs, 10'b0);
    end
    abort = 0;
    @(negedge clk);
    vectors++;
    if (obs !== 10'b0) begin
      miscompares++; $display("[TB] FAIL reset_over_start got %b want %b", obs, 10'b0);
    end
    reset = 0; start = 0; d_reset = 0;
    @(negedge clk);
    vectors++;
    if (obs !== 10'b0) begin
      miscompares++; $display("[TB] FAIL idle_after_reset got %b want %b", obs, 10'b0);
    end
  endtask

  task automatic test_basic();
    int cyc, n_sr, n_lf, done_at;
    logic [9:0] e;
    exp_q.delete();
    push_run(3);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, NB - 1));
    cyc = 0; n_sr = 0; n_lf = 0; done_at = -1;
    window = 8'd3; start = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 0; cyc++;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("[TB] FAIL basic_trace cyc %0d got %b want %b", cyc, obs, e);
      end
      if (sr_en) n_sr++;
      if (lfsr_en) n_lf++;
      if (done && done_at < 0) done_at = cyc;
    end
    vectors++;
    if (done_at != 1 + NB * (3 + S + 2) + 1) begin
      miscompares++; $display("[TB] FAIL basic_done_cycle got %0d want %0d", done_at, 1 + NB * (3 + S + 2) + 1);
    end
    vectors++;
    if (n_sr != NB) begin
      miscompares++; $display("[TB] FAIL basic_sr_count got %0d want %0d", n_sr, NB);
    end
    vectors++;
    if (n_lf != NB) begin
      miscompares++; $display("[TB] FAIL basic_lfsr_count got %0d want %0d", n_lf, NB);
    end
  endtask

  task automatic test_window_zero();
    int run_len;
    logic [9:0] e;
    exp_q.delete();
    push_run(0);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, NB - 1));
    run_len = 0;
    window = 8'd0; start = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 0;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("[TB] FAIL win0_trace got %b want %b", obs, e);
      end
      if (ro_en) run_len++;
      else if (run_len > 0) begin
        vectors++;
        if (run_len != 1) begin
          miscompares++; $display("[TB] FAIL win0_measure_len got %0d want 1", run_len);
        end
        run_len = 0;
      end
    end
  endtask

  task automatic test_random();
    int w;
    logic [9:0] e;
    for (int r = 0; r < 6; r++) begin
      w = $urandom_range(0, 10);
      exp_q.delete();
      push_run(w);
      exp_q.push_back(ev(0, 0, 0, 0, 0, 0, NB - 1));
      window = 8'(w); start = 1;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
          miscompares++; $display("[TB] FAIL random_trace w=%0d got %b want %b", w, obs, e);
        end
        start = 1'($urandom_range(0, 1));
        window = 8'($urandom);
      end
    end
    start = 0;
  endtask

  task automatic test_abort();
    logic [9:0] e;
    exp_q.delete();
    push_run(3);
    window = 8'd3; start = 1;
    for (int i = 0; i <= 1 + 2 * (3 + S + 2) + 2; i++) begin
      @(negedge clk);
      start = 0;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("[TB] FAIL abort_trace step %0d got %b want %b", i, obs, e);
      end
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    vectors++;
    if (obs[9:2] !== 8'b0) begin
      miscompares++; $display("[TB] FAIL abort_idle got %b want 00000000", obs[9:2]);
    end
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (obs[9:2] !== 8'b0) begin
        miscompares++; $display("[TB] FAIL abort_no_strobes got %b want 00000000", obs[9:2]);
      end
    end
    abort = 1; start = 1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++; $display("[TB] FAIL abort_blocks_start busy got %b want 0", busy);
      end
    end
    abort = 0; start = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    exp_q.delete();
    push_run(3);
    window = 8'd3; start = 1;
    for (int i = 0; i <= 1 + (3 + S + 2) + 1 + 3; i++) begin
      @(negedge clk);
      start = 0;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("[TB] FAIL resetmid_trace step %0d got %b want %b", i, obs, e);
      end
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    vectors++;
    if (obs !== 10'b0) begin
      miscompares++; $display("[TB] FAIL resetmid_outputs got %b want %b", obs, 10'b0);
    end
    exp_q.delete();
    push_run(3);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, NB - 1));
    start = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 0;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("[TB] FAIL resetmid_rerun got %b want %b", obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w, cyc, first_done, second_done;
    logic [9:0] e;
    w = $urandom_range(1, 6);
    exp_q.delete();
    push_run(w);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, NB - 1));
    push_run(w);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, NB - 1));
    cyc = 0; first_done = -1; second_done = -1;
    window = 8'(w); start = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++; $display("[TB] FAIL b2b_trace cyc %0d got %b want %b", cyc, obs, e);
      end
      if (done) begin
        if (first_done < 0) first_done = cyc;
        else if (second_done < 0) second_done = cyc;
      end
      // Window only matters in the idle cycle where the next start is sampled.
      window = (e[2] == 1'b0) ? 8'(w) : 8'($urandom);
    end
    start = 0;
    vectors++;
    if (second_done - first_done != (1 + NB * (w + S + 2) + 1) + 1) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_period got %0d want %0d", second_done - first_done, 1 + NB * (w + S + 2) + 2);
    end
  endtask

  task automatic test_default();
    int n;
    d_window = 8'd255; d_start = 1;
    @(negedge clk);
    d_start = 0;
    n = 1;
    while (d_done !== 1'b1 && n < 70000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (d_done !== 1'b1 || n != 1 + 256 * 259 + 1) begin
      miscompares++; $display("[TB] FAIL default_latency got %0d want %0d", n, 1 + 256 * 259 + 1);
    end
    vectors++;
    if (d_bit_idx !== 8'd255) begin
      miscompares++; $display("[TB] FAIL default_bit_idx got %0d want 255", d_bit_idx);
    end
    @(negedge clk);
    vectors++;
    if (d_busy !== 1'b0 || d_done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL default_after_done busy %b done %b want 0 0", d_busy, d_done);
    end
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; window = '0;
    d_reset = 1; d_start = 0; d_abort = 0; d_window = '0;
    test_reset();
    test_basic();
    test_window_zero();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_default();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
